// File: rtl/title_banner_if.sv
// Signal bundle between the title-screen banner controller and its video/input environment.
// No valid/ready handshake here: frame_tick is a one-cycle strobe, everything else is a level sampled every clock.
interface title_banner_if;
  logic         show;
  logic         start_btn;
  logic         frame_tick;
  logic [9:0]   pixel_x;
  logic [9:0]   pixel_y;
  logic [4:0]   rom_addr;
  logic [127:0] rom_data;
  logic         title_on;
  logic         busy;
  logic         done;
  // Debug view of the sequencer: state code (IDLE=0, SLIDE=1, SHOW=2, BLINK=3), x_pos, visible.
  logic [1:0]   state_dbg;
  logic [10:0]  x_pos_dbg;
  logic         visible_dbg;

  modport master (
    output show, start_btn, frame_tick, pixel_x, pixel_y, rom_data,
    input  rom_addr, title_on, busy, done, state_dbg, x_pos_dbg, visible_dbg
  );

  modport slave (
    input  show, start_btn, frame_tick, pixel_x, pixel_y, rom_data,
    output rom_addr, title_on, busy, done, state_dbg, x_pos_dbg, visible_dbg
  );
endinterface

// File: rtl/title_banner_ctrl.sv
// Title banner sequencer: slides a 128x32 bitmap in from the right edge, holds it,
// blinks it after a start press, then pulses done. Also renders the banner pixel.
module title_banner_ctrl #(
   parameter int X_TARGET      = 256,
   parameter int Y_TOP         = 200,
   parameter int SLIDE_STEP    = 4,
   parameter int BLINK_FRAMES  = 8,
   parameter int BLINK_TOGGLES = 6
) (
   input logic           clk,
   input logic           reset,
   title_banner_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, SLIDE = 2'd1, SHOW = 2'd2, BLINK = 2'd3} state_t;

   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam int TW = $clog2(BLINK_TOGGLES + 1);
   localparam logic [10:0]   X_OFF  = 11'd640;
   localparam logic [10:0]   X_TGT  = 11'(X_TARGET);
   localparam logic [10:0]   X_SNAP = 11'(X_TARGET + SLIDE_STEP);
   localparam logic [10:0]   STEP   = 11'(SLIDE_STEP);
   localparam logic [9:0]    Y_LO   = 10'(Y_TOP);
   localparam logic [9:0]    Y_HI   = 10'(Y_TOP + 31);
   localparam logic [4:0]    Y_LO5  = 5'(Y_TOP);
   localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [TW-1:0] T_LAST = TW'(BLINK_TOGGLES - 1);

   state_t        state_q, state_d;
   logic [10:0]   x_pos_q, x_pos_d;
   logic          visible_q, visible_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [TW-1:0] toggle_q, toggle_d;
   logic          done_q, done_d;
   logic          start_btn_d;
   logic          title_on_q;
   logic          start_edge;

   assign start_edge = bus.start_btn & ~start_btn_d;

   always_comb begin
      state_d   = state_q;
      x_pos_d   = x_pos_q;
      visible_d = visible_q;
      frame_d   = frame_q;
      toggle_d  = toggle_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.show) begin
               state_d   = SLIDE;
               visible_d = 1'b1;
            end
         end
         SLIDE: begin
            // A start press skips the rest of the slide, even on a frame_tick cycle.
            if (start_edge) begin
               x_pos_d = X_TGT;
               state_d = SHOW;
            end else if (bus.frame_tick) begin
               if (x_pos_q <= X_SNAP) begin
                  x_pos_d = X_TGT;
                  state_d = SHOW;
               end else begin
                  x_pos_d = x_pos_q - STEP;
               end
            end
         end
         SHOW: begin
            if (start_edge) begin
               state_d  = BLINK;
               frame_d  = '0;
               toggle_d = '0;
            end
         end
         BLINK: begin
            if (bus.frame_tick) begin
               if (frame_q == F_LAST) begin
                  frame_d   = '0;
                  visible_d = ~visible_q;
                  if (toggle_q == T_LAST) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     toggle_d = toggle_q + 1'b1;
                  end
               end else begin
                  frame_d = frame_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Dropping show aborts any sequence silently.
      if (state_q != IDLE && !bus.show) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
      if (state_d == IDLE) begin
         x_pos_d   = X_OFF;
         visible_d = 1'b0;
         frame_d   = '0;
         toggle_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         x_pos_q     <= X_OFF;
         visible_q   <= 1'b0;
         frame_q     <= '0;
         toggle_q    <= '0;
         done_q      <= 1'b0;
         start_btn_d <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_pos_q     <= x_pos_d;
         visible_q   <= visible_d;
         frame_q     <= frame_d;
         toggle_q    <= toggle_d;
         done_q      <= done_d;
         start_btn_d <= bus.start_btn;
      end
   end

   // Pixel path: column offset only needs the low 7 bits once in_box holds.
   logic [10:0] px;
   logic [6:0]  col;
   logic        in_box;

   assign px     = {1'b0, bus.pixel_x};
   assign col    = bus.pixel_x[6:0] - x_pos_q[6:0];
   assign in_box = (bus.pixel_y >= Y_LO) && (bus.pixel_y <= Y_HI) &&
                   (px >= x_pos_q) && (px < x_pos_q + 11'd128);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) title_on_q <= 1'b0;
      else       title_on_q <= in_box & visible_q & bus.rom_data[col];
   end

   assign bus.rom_addr    = bus.pixel_y[4:0] - Y_LO5;
   assign bus.title_on    = title_on_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = done_q;
   assign bus.state_dbg   = state_q;
   assign bus.x_pos_dbg   = x_pos_q;
   assign bus.visible_dbg = visible_q;

endmodule

// File: tb/tb_title_banner_ctrl.sv
// Bench for title_banner_ctrl: randomized frame pacing and pixel probes against
// closed-form expectations of slide position, blink phase and banner coverage.
module tb_title_banner_ctrl;
  localparam int XT   = 256;
  localparam int YT   = 200;
  localparam int STEP = 4;
  localparam int BF   = 8;
  localparam int BT   = 6;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SLIDE = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;
  localparam logic [1:0] S_BLINK = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  title_banner_if bus ();

  title_banner_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected banner x after n slide frames: straight-line motion clamped at the target.
  function automatic logic [10:0] slide_x(int n);
    int v;
    v = 640 - STEP * n;
    if (v < XT) v = XT;
    return 11'(v);
  endfunction

  // Expected visibility after n blink frames: starts visible, flips every BF frames.
  function automatic logic blink_vis(int n);
    return ((n / BF) % 2) == 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.show = 1'b0;
    bus.start_btn = 1'b0;
    bus.frame_tick = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (bus.title_on !== 1'b0) begin tests_failed++; $display("FAIL reset_title_on got %b exp 0", bus.title_on); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", bus.done); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    tests_run++; if (bus.x_pos_dbg !== 11'd640) begin tests_failed++; $display("FAIL reset_x got %0d exp 640", bus.x_pos_dbg); end
    tests_run++; if (bus.visible_dbg !== 1'b0) begin tests_failed++; $display("FAIL reset_visible got %b exp 0", bus.visible_dbg); end
    step();
    tests_run++; if (bus.state_dbg !== S_IDLE) begin tests_failed++; $display("FAIL idle_hold got %0d exp %0d", bus.state_dbg, S_IDLE); end
  endtask

  task automatic test_slide();
    logic [10:0] exp_x;
    do_reset();
    bus.show = 1'b1;
    step();
    tests_run++; if (bus.state_dbg !== S_SLIDE) begin tests_failed++; $display("FAIL slide_entry got %0d exp %0d", bus.state_dbg, S_SLIDE); end
    tests_run++; if (bus.visible_dbg !== 1'b1) begin tests_failed++; $display("FAIL slide_visible got %b exp 1", bus.visible_dbg); end
    for (int k = 1; k <= 100; k++) begin
      tick();
      exp_x = slide_x(k);
      tests_run++; if (bus.x_pos_dbg !== exp_x) begin tests_failed++; $display("FAIL slide_x k=%0d got %0d exp %0d", k, bus.x_pos_dbg, exp_x); end
      tests_run++; if (bus.state_dbg !== ((exp_x > 11'(XT)) ? S_SLIDE : S_SHOW)) begin tests_failed++; $display("FAIL slide_state k=%0d got %0d", k, bus.state_dbg); end
      repeat ($urandom_range(0, 2)) step();
      tests_run++; if (bus.x_pos_dbg !== exp_x) begin tests_failed++; $display("FAIL slide_hold k=%0d got %0d exp %0d", k, bus.x_pos_dbg, exp_x); end
    end
  endtask

  task automatic test_pixels();
    logic [127:0] rd;
    logic         exp_on;
    logic [4:0]   exp_a;
    int           px, py;
    // Banner parked at XT in SHOW from the previous task.
    bus.rom_data = 128'h2;
    bus.pixel_y = 10'(YT);
    bus.pixel_x = 10'(XT);
    step();
    tests_run++; if (bus.title_on !== 1'b0) begin tests_failed++; $display("FAIL pix_col0 got %b exp 0", bus.title_on); end
    bus.pixel_x = 10'(XT + 1);
    #1;
    tests_run++; if (bus.title_on !== 1'b0) begin tests_failed++; $display("FAIL pix_latency got %b exp 0", bus.title_on); end
    step();
    tests_run++; if (bus.title_on !== 1'b1) begin tests_failed++; $display("FAIL pix_col1 got %b exp 1", bus.title_on); end
    for (int i = 0; i < 80; i++) begin
      py = $urandom_range(190, 240);
      px = $urandom_range(230, 400);
      rd = {$urandom, $urandom, $urandom, $urandom};
      bus.rom_data = rd;
      bus.pixel_x = 10'(px);
      bus.pixel_y = 10'(py);
      #1;
      exp_a = 5'(py - YT);
      tests_run++; if (bus.rom_addr !== exp_a) begin tests_failed++; $display("FAIL rom_addr y=%0d got %0d exp %0d", py, bus.rom_addr, exp_a); end
      exp_on = (py >= YT && py <= YT + 31 && px >= XT && px < XT + 128) ? rd[px - XT] : 1'b0;
      step();
      tests_run++; if (bus.title_on !== exp_on) begin tests_failed++; $display("FAIL pix_rand x=%0d y=%0d got %b exp %b", px, py, bus.title_on, exp_on); end
    end
  endtask

  task automatic test_partial();
    do_reset();
    bus.show = 1'b1;
    step();
    repeat (5) tick();
    bus.rom_data = '1;
    bus.pixel_y = 10'(YT + 10);
    bus.pixel_x = 10'd619;
    step();
    tests_run++; if (bus.title_on !== 1'b0) begin tests_failed++; $display("FAIL partial_left got %b exp 0", bus.title_on); end
    bus.pixel_x = 10'd620;
    step();
    tests_run++; if (bus.title_on !== 1'b1) begin tests_failed++; $display("FAIL partial_edge got %b exp 1", bus.title_on); end
    bus.pixel_x = 10'd639;
    step();
    tests_run++; if (bus.title_on !== 1'b1) begin tests_failed++; $display("FAIL partial_right got %b exp 1", bus.title_on); end
  endtask

  task automatic test_snap();
    do_reset();
    bus.show = 1'b1;
    step();
    repeat (35) tick();
    tests_run++; if (bus.x_pos_dbg !== 11'd500) begin tests_failed++; $display("FAIL snap_pre got %0d exp 500", bus.x_pos_dbg); end
    bus.start_btn = 1'b1;
    tick();
    tests_run++; if (bus.x_pos_dbg !== 11'(XT)) begin tests_failed++; $display("FAIL snap_x got %0d exp %0d", bus.x_pos_dbg, XT); end
    tests_run++; if (bus.state_dbg !== S_SHOW) begin tests_failed++; $display("FAIL snap_state got %0d exp %0d", bus.state_dbg, S_SHOW); end
    bus.start_btn = 1'b0;
    repeat (3) tick();
    tests_run++; if (bus.state_dbg !== S_SHOW || bus.x_pos_dbg !== 11'(XT)) begin tests_failed++; $display("FAIL show_still state %0d x %0d exp %0d x %0d", bus.state_dbg, bus.x_pos_dbg, S_SHOW, XT); end
  endtask

  task automatic test_blink();
    int done_cnt = 0;
    // Starts in SHOW left by test_snap.
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
    tests_run++; if (bus.state_dbg !== S_BLINK) begin tests_failed++; $display("FAIL blink_entry got %0d exp %0d", bus.state_dbg, S_BLINK); end
    for (int k = 1; k <= BF * BT; k++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
      if (k < BF * BT) begin
        tests_run++; if (bus.visible_dbg !== blink_vis(k)) begin tests_failed++; $display("FAIL blink_vis k=%0d got %b exp %b", k, bus.visible_dbg, blink_vis(k)); end
        tests_run++; if (bus.state_dbg !== S_BLINK) begin tests_failed++; $display("FAIL blink_state k=%0d got %0d exp %0d", k, bus.state_dbg, S_BLINK); end
      end else begin
        tests_run++; if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL blink_done got %b exp 1", bus.done); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL blink_busy got %b exp 0", bus.busy); end
        bus.show = 1'b0;
      end
      if (k == 20) begin
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        if (bus.done === 1'b1) done_cnt++;
        tests_run++; if (bus.state_dbg !== S_BLINK || bus.visible_dbg !== blink_vis(k)) begin tests_failed++; $display("FAIL blink_ignore_start state %0d vis %b exp %0d vis %b", bus.state_dbg, bus.visible_dbg, S_BLINK, blink_vis(k)); end
      end
      if (k < BF * BT) begin
        repeat ($urandom_range(0, 2)) begin
          step();
          if (bus.done === 1'b1) done_cnt++;
        end
      end
    end
    repeat (4) begin
      step();
      if (bus.done === 1'b1) done_cnt++;
    end
    tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL done_pulses got %0d exp 1", done_cnt); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL after_done_busy got %b exp 0", bus.busy); end
  endtask

  task automatic enter_blink();
    do_reset();
    bus.show = 1'b1;
    step();
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
    step();
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
    bus.rom_data = '1;
    bus.pixel_y = 10'(YT + 5);
    bus.pixel_x = 10'(XT + 44);
  endtask

  task automatic test_abort();
    int done_cnt = 0;
    enter_blink();
    tests_run++; if (bus.state_dbg !== S_BLINK) begin tests_failed++; $display("FAIL abort_setup got %0d exp %0d", bus.state_dbg, S_BLINK); end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    tests_run++; if (bus.title_on !== blink_vis(20)) begin tests_failed++; $display("FAIL abort_pre_on got %b exp %b", bus.title_on, blink_vis(20)); end
    bus.show = 1'b0;
    step();
    if (bus.done === 1'b1) done_cnt++;
    tests_run++; if (bus.state_dbg !== S_IDLE || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL abort_idle state %0d busy %b exp %0d busy 0", bus.state_dbg, bus.busy, S_IDLE); end
    step();
    if (bus.done === 1'b1) done_cnt++;
    tests_run++; if (bus.title_on !== 1'b0) begin tests_failed++; $display("FAIL abort_title_on got %b exp 0", bus.title_on); end
    repeat (3) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    tests_run++; if (done_cnt != 0) begin tests_failed++; $display("FAIL abort_done got %0d pulses exp 0", done_cnt); end
  endtask

  task automatic test_async_reset();
    enter_blink();
    repeat (3) tick();
    step();
    tests_run++; if (bus.title_on !== 1'b1) begin tests_failed++; $display("FAIL areset_pre_on got %b exp 1", bus.title_on); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if (bus.title_on !== 1'b0) begin tests_failed++; $display("FAIL areset_title_on got %b exp 0", bus.title_on); end
    tests_run++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL areset_busy_done got %b%b exp 00", bus.busy, bus.done); end
    tests_run++; if (bus.state_dbg !== S_IDLE || bus.x_pos_dbg !== 11'd640) begin tests_failed++; $display("FAIL areset_state state %0d x %0d exp 0 x 640", bus.state_dbg, bus.x_pos_dbg); end
    step();
    reset = 1'b0;
    bus.show = 1'b0;
  endtask

  task automatic test_reset_start_held();
    reset = 1'b1;
    bus.show = 1'b1;
    bus.start_btn = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    tests_run++; if (bus.state_dbg !== S_SLIDE || bus.x_pos_dbg !== 11'd640) begin tests_failed++; $display("FAIL held_first state %0d x %0d exp 1 x 640", bus.state_dbg, bus.x_pos_dbg); end
    repeat (3) step();
    tests_run++; if (bus.state_dbg !== S_SLIDE || bus.x_pos_dbg !== 11'd640) begin tests_failed++; $display("FAIL held_no_edge state %0d x %0d exp 1 x 640", bus.state_dbg, bus.x_pos_dbg); end
    bus.start_btn = 1'b0;
    bus.show = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.show = 1'b0;
    bus.start_btn = 1'b0;
    bus.frame_tick = 1'b0;
    bus.pixel_x = '0;
    bus.pixel_y = '0;
    bus.rom_data = '0;
    test_reset();
    test_slide();
    test_pixels();
    test_partial();
    test_snap();
    test_blink();
    test_abort();
    test_async_reset();
    test_reset_start_held();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/title_banner_ctrl.md
TITLE_BANNER_CTRL -- requirements
Module: title_banner_ctrl

Interface
REQ-001 SHALL have parameter X_TARGET, default 256, final left x of banner.
REQ-002 SHALL have parameter Y_TOP, default 200, top row of banner.
REQ-003 SHALL have parameter SLIDE_STEP, default 4, pixels moved left per frame in SLIDE.
REQ-004 SHALL have parameter BLINK_FRAMES, default 8, frames per blink half-period.
REQ-005 SHALL have parameter BLINK_TOGGLES, default 6, visibility toggles before completion.
REQ-006 SHALL have port clk  in  1  system/pixel clock, all state on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port show  in  1  level; 1 = title screen requested.
REQ-009 SHALL have port start_btn  in  1  debounced start button level.
REQ-010 SHALL have port frame_tick  in  1  one-cycle pulse per video frame.
REQ-011 SHALL have port pixel_x  in  10  current scan column (0..639).
REQ-012 SHALL have port pixel_y  in  10  current scan row (0..479).
REQ-013 SHALL have port rom_addr  out  5  row address to 32x128 word bitmap ROM.
REQ-014 SHALL have port rom_data  in  128  ROM row, bit index 0 = leftmost pixel.
REQ-015 SHALL have port title_on  out  1  registered banner pixel-on.
REQ-016 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-017 SHALL have port done  out  1  one-cycle pulse on blink sequence completion.

Function
REQ-018 SHALL implement states IDLE, SLIDE, SHOW, BLINK.
REQ-019 SHALL hold 11-bit x_pos; IDLE forces x_pos = 640, visible = 0.
REQ-020 IDLE -> SLIDE when show = 1; visible = 1 on entry.
REQ-021 In SLIDE, on frame_tick, x_pos SHALL become max(x_pos - SLIDE_STEP, X_TARGET), no underflow; reaching X_TARGET -> SHOW on same update.
REQ-022 start_edge SHALL be start_btn & ~start_btn_d (one-cycle registered delay).
REQ-023 start_edge in SLIDE SHALL snap x_pos to X_TARGET and go to SHOW, priority over a simultaneous frame_tick.
REQ-024 start_edge in SHOW SHALL go to BLINK, clearing frame counter and toggle counter.
REQ-025 In BLINK, frame counter SHALL count frame_ticks; at BLINK_FRAMES it SHALL clear, invert visible, and increment toggle counter.
REQ-026 When toggle counter reaches BLINK_TOGGLES, SHALL pulse done for one cycle, go to IDLE.
REQ-027 show = 0 in any non-IDLE state SHALL go to IDLE next cycle without done; this overrides all other transitions.
REQ-028 start_edge in IDLE or BLINK SHALL be ignored.
REQ-029 rom_addr SHALL be combinational (pixel_y - Y_TOP)[4:0].
REQ-030 in_box = pixel_y in [Y_TOP, Y_TOP+31] and pixel_x >= x_pos and pixel_x < x_pos+128 (11-bit compare).
REQ-031 title_on SHALL register in_box & visible & rom_data[pixel_x - x_pos], latency exactly 1 clk from pixel_x/pixel_y.
REQ-032 Portions with x >= 640 are never addressed; partially entered banner shows only its left columns.
REQ-033 busy SHALL be combinational from state.

Reset
REQ-034 reset SHALL asynchronously force state IDLE, x_pos 640, visible 0, counters 0, start_btn_d 0, title_on 0, done 0.
REQ-035 reset mid-SLIDE or mid-BLINK SHALL abandon the sequence, no done pulse.
REQ-036 First cycle after reset release SHALL behave as IDLE; start_btn held high through reset SHALL not produce start_edge.

Verification
REQ-037 show=1, 100 frame_ticks, SLIDE_STEP=4 -> x_pos 636,632,... reaches 256 after 96 ticks, state SHOW, no further motion.
REQ-038 In SHOW, pixel_y=200, pixel_x=256, rom_data bit0=0, bit1=1 -> title_on 0 then 1 at pixel_x=257, each 1 clk late.
REQ-039 start_edge in same cycle as frame_tick during SLIDE at x_pos=500 -> x_pos=256, state SHOW next cycle.
REQ-040 SHOW, start_edge, 48 frame_ticks -> visible toggles every 8 ticks, 6 toggles, single done pulse, busy=0 after.
REQ-041 show dropped after 20 ticks in BLINK -> IDLE next cycle, done never asserted, title_on 0.
REQ-042 reset asserted mid-BLINK between clock edges -> outputs 0 immediately, state IDLE, x_pos 640.
